uart_tx_mmio: RTL and testbench
===============================

UART_TX_MMIO -- requirements
Module: uart_tx_mmio

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the bus data and address width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1001_0000, the base of a 16-byte register window.
REQ-003 SHALL have parameter CLKS_PER_BIT, default 16, the clock cycles per serial bit, legal range 4..65535.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the TX FIFO entries, fixed at 4.
REQ-005 SHALL use a single clock domain; reset is synchronous and active-high.
REQ-006 SHALL have port clk  input  1  system clock, rising edge.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port MemWrite  input  1  core store strobe.
REQ-009 SHALL have port Address  input  DATA_WIDTH  core data address.
REQ-010 SHALL have port WriteData  input  DATA_WIDTH  core store data.
REQ-011 SHALL have port ReadData  output  DATA_WIDTH  register read data, combinational from Address.
REQ-012 SHALL have port Sel  output  1  high when Address is inside the window, combinational; the core-side read mux uses it.
REQ-013 SHALL have port tx  output  1  serial line, registered, idle high.

Function
REQ-014 SHALL decode the window as Address[31:4]==BASE_ADDR[31:4] and the register as Address[3:2]; Address[1:0] is ignored.
REQ-015 SHALL implement this register map: 0x0 TXDATA (W: push WriteData[7:0]; R: 0); 0x4 STATUS (R only); 0x8 CTRL (R/W, bit0 = enable); 0xC reserved (R: 0, W: ignored).
REQ-016 SHALL define STATUS as follows: bit0 busy (FSM not IDLE), bit1 full (count==4), bit2 empty (count==0), bits[5:3] count 0..4, bit6 overflow sticky, others 0.
REQ-017 SHALL take register writes effect at the clk edge where MemWrite=1 and Sel=1; writes outside the window SHALL have no effect.
REQ-018 SHALL drive ReadData=0 when Sel=0.
REQ-019 SHALL clear overflow on any write to STATUS; write data is ignored for this clear.
REQ-020 SHALL implement the FIFO as a 4-entry circular buffer with 2-bit read/write pointers wrapping 3->0, plus a 3-bit count.
REQ-021 SHALL accept a push when count<4, or when count==4 and a pop occurs the same edge.
REQ-022 SHALL drop a push that is not accepted; overflow SHALL set on that edge and FIFO contents SHALL be unchanged.
REQ-023 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on push+pop.
REQ-024 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-025 SHALL pop in IDLE on an edge where enable=1 and count>0, latching the head byte into a shift register and entering START with tx=0.
REQ-026 SHALL hold each state for CLKS_PER_BIT cycles using a baud counter that reloads on every state or bit change.
REQ-027 SHALL, after START, enter DATA and send 8 bits LSB first, with a 3-bit bit index wrapping 7->0 on exit to STOP.
REQ-028 SHALL drive tx=1 in STOP; at the end of STOP it SHALL enter START directly, popping the next byte, if enable=1 and count>0, else IDLE.
REQ-029 SHALL make each frame exactly 10*CLKS_PER_BIT cycles, with no idle gap between back-to-back frames.
REQ-030 SHALL let an in-progress frame complete when enable is cleared mid-frame; no further pop occurs.
REQ-031 SHALL drive tx low one cycle after the push edge for a push to an empty FIFO in IDLE with enable=1, i.e. at the second edge.

Reset
REQ-032 SHALL, with reset=1 at an edge, set tx=1, FSM=IDLE, pointers=0, count=0, overflow=0, enable=0, and baud/bit counters=0.
REQ-033 SHALL abort a frame on reset mid-frame; tx=1 from that edge and queued bytes are discarded.
REQ-034 SHALL give reset priority over a simultaneous register write.

Verification
REQ-035 SHALL verify: CLKS_PER_BIT=4, write CTRL=1, write TXDATA=0xA5 -> tx low 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then high 4 cycles; STATUS busy=1 during the frame.
REQ-036 SHALL verify: enable=0, 5 writes of 0x11..0x15 -> STATUS count=4, full=1, overflow=1; then enable=1 -> 0x11..0x14 transmitted in order back-to-back and 0x15 never sent.
REQ-037 SHALL verify: full FIFO with a pop and a push on the same edge -> push accepted, count stays 4, overflow stays 0.
REQ-038 SHALL verify: reset asserted during DATA bit 3 -> tx=1 and STATUS=0x04 at the next cycle; no frame resumes.
REQ-039 SHALL verify: write to BASE_ADDR+0x20 and to 0x0000_0000 -> Sel=0, ReadData=0, and no change in any register or tx.
REQ-040 SHALL verify: overflow set, then a write to STATUS -> overflow=0 the next cycle, with count unchanged.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a
// 4-entry TX FIFO, CTRL enable bit and sticky overflow flag.
module uart_tx_mmio #(
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0000,
    parameter int unsigned           CLKS_PER_BIT = 16,
    parameter int unsigned           FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  MemWrite,
    input  logic [DATA_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] ReadData,
    output logic                  Sel,
    output logic                  tx
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  CNT_FULL = 3'(FIFO_DEPTH);

    state_e      state_q, state_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        en_q, en_d;
    logic        ovf_q, ovf_d;
    logic [7:0]  mem_q [4];
    logic [7:0]  mem_d [4];

    logic [1:0]  reg_sel;
    logic        wr_en;
    logic        push;
    logic        push_ok;
    logic        pop;
    logic        baud_done;
    logic        have_data;
    logic [6:0]  status;
    logic        unused_ok;

    assign Sel       = Address[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4];
    assign reg_sel   = Address[3:2];
    assign wr_en     = MemWrite && Sel;
    assign push      = wr_en && (reg_sel == 2'd0);
    assign baud_done = baud_q == BAUD_MAX;
    assign have_data = en_q && (cnt_q != 3'd0);
    assign tx        = tx_q;
    assign unused_ok = ^{Address[1:0], WriteData[DATA_WIDTH-1:8]};

    assign status = {ovf_q, cnt_q, cnt_q == 3'd0, cnt_q == CNT_FULL,
                     state_q != IDLE};

    always_comb begin
        ReadData = '0;
        if (Sel) begin
            unique case (reg_sel)
                2'd1:    ReadData[6:0] = status;
                2'd2:    ReadData[0]   = en_q;
                default: ;
            endcase
        end
    end

    // Frame sequencer; STOP chains straight into START so frames abut.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    state_d = START;
                    baud_d  = '0;
                    shift_d = mem_q[rd_ptr_q];
                end
            end
            START: begin
                if (baud_done) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (have_data) begin
                        pop     = 1'b1;
                        state_d = START;
                        shift_d = mem_q[rd_ptr_q];
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    // A push into a full FIFO still fits if the head leaves this edge.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        en_d     = en_q;
        ovf_d    = ovf_q;
        push_ok  = push && ((cnt_q != CNT_FULL) || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = WriteData[7:0];
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        unique case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: ;
        endcase
        if (push && !push_ok) begin
            ovf_d = 1'b1;
        end
        if (wr_en && (reg_sel == 2'd1)) begin
            ovf_d = 1'b0;
        end
        if (wr_en && (reg_sel == 2'd2)) begin
            en_d = WriteData[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            en_q     <= 1'b0;
            ovf_q    <= 1'b0;
            mem_q    <= '{default: 8'h00};
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            en_q     <= en_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: randomized and directed checks of uart_tx_mmio
// against a frame-position reference model.
module tb_uart_tx_mmio;

    localparam int          C     = 4;
    localparam int          FRAME = 10 * C;
    localparam logic [31:0] BASE  = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;
    logic        tx;

    int n_checks = 0;
    int n_errors = 0;

    // Reference: byte queue, position inside current frame (-1 = idle).
    logic [7:0] mq[$];
    int         pos   = -1;
    logic [7:0] cur   = 8'h00;
    bit         m_en  = 1'b0;
    bit         m_ovf = 1'b0;

    uart_tx_mmio #(.CLKS_PER_BIT(C)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .Address   (Address),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Sel       (Sel),
        .tx        (tx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (pos %0d)",
                     tag, got, exp, pos);
        end
    endtask

    function automatic logic exp_tx();
        int k;
        if (pos < 0) return 1'b1;
        k = pos / C;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur[k-1];
    endfunction

    function automatic logic [31:0] exp_status();
        int n;
        n = mq.size();
        return {25'b0, m_ovf, 3'(n), n == 0, n == 4, pos >= 0};
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a[31:4] != BASE[31:4]) return 32'h0;
        case (a[3:2])
            2'd1:    return exp_status();
            2'd2:    return {31'b0, m_en};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic rst, input logic we,
                              input logic [31:0] a, input logic [31:0] d);
        bit pop;
        if (rst) begin
            mq.delete();
            pos   = -1;
            m_en  = 1'b0;
            m_ovf = 1'b0;
            return;
        end
        pop = 1'b0;
        if (pos < 0 || pos == FRAME - 1) begin
            if (m_en && mq.size() > 0) pop = 1'b1;
            else pos = -1;
        end else begin
            pos++;
        end
        if (pop) begin
            cur = mq.pop_front();
            pos = 0;
        end
        if (we && a[31:4] == BASE[31:4]) begin
            case (a[3:2])
                2'd0: begin
                    if (mq.size() < 4) mq.push_back(d[7:0]);
                    else m_ovf = 1'b1;
                end
                2'd1:    m_ovf = 1'b0;
                2'd2:    m_en  = d[0];
                default: ;
            endcase
        end
    endtask

    task automatic cyc(input logic we, input logic [31:0] a,
                       input logic [31:0] d, input logic rst);
        MemWrite  = we;
        Address   = a;
        WriteData = d;
        reset     = rst;
        #1;
        check("sel", {31'b0, Sel}, {31'b0, a[31:4] == BASE[31:4]});
        if (!rst) check("rdata", ReadData, exp_rd(a));
        @(posedge clk);
        model_step(rst, we, a, d);
        #1;
        MemWrite = 1'b0;
        reset    = 1'b0;
        Address  = BASE + 32'h4;
        #1;
        check("tx", {31'b0, tx}, {31'b0, exp_tx()});
        check("status", ReadData, exp_status());
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        cyc(1'b1, a, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, BASE + 32'h4, 32'h0, 1'b0);
    endtask

    logic [31:0] ra;
    logic [31:0] rd;
    logic        rwe;
    logic        rrst;
    int          p;

    initial begin
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, 1'b1);
        idle(2);

        // Single 0xA5 frame
        wr(BASE + 32'h8, 32'h1);
        wr(BASE, 32'hA5);
        idle(FRAME + 4);

        // Overflow, clear, then drain in order
        wr(BASE + 32'h8, 32'h0);
        for (int i = 0; i < 5; i++) wr(BASE, 32'h11 + i);
        idle(2);
        wr(BASE + 32'h4, 32'hFFFF_FFFF);
        wr(BASE + 32'h8, 32'h1);
        idle(4 * FRAME + 4);

        // Full FIFO: pop and push on the same edge
        wr(BASE + 32'h8, 32'h0);
        for (int i = 0; i < 4; i++) wr(BASE, $urandom);
        wr(BASE + 32'h8, 32'h1);
        wr(BASE, $urandom);
        idle(5 * FRAME + 4);

        // Reset during data bit 3 with bytes queued
        wr(BASE, $urandom);
        wr(BASE, $urandom);
        wr(BASE, $urandom);
        for (int i = 0; i < 3 * FRAME && pos != 4 * C + 1; i++) idle(1);
        cyc(1'b0, BASE + 32'h4, 32'h0, 1'b1);
        wr(BASE + 32'h8, 32'h1);
        idle(2 * FRAME);

        // Out-of-window writes during a frame
        wr(BASE, $urandom);
        idle(3);
        wr(BASE + 32'h20, 32'h55);
        wr(BASE + 32'h24, 32'h0);
        wr(BASE + 32'h28, 32'h0);
        wr(32'h0000_0000, 32'h77);
        wr(32'h0000_0008, 32'h0);
        wr(BASE + 32'h10, 32'h0);
        idle(FRAME);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            p   = $urandom_range(0, 15);
            rd  = $urandom;
            rwe = $urandom_range(0, 3) == 0;
            case (p)
                0, 1, 2: ra = BASE;
                3:       ra = BASE + 32'h1 + ($urandom_range(0, 2));
                4:       ra = BASE + 32'h4;
                5, 6: begin
                    ra = BASE + 32'h8;
                    rd = {31'b0, $urandom_range(0, 3) != 0};
                end
                7:       ra = BASE + 32'hC;
                8:       ra = BASE + 32'h20 + ($urandom_range(0, 3) * 4);
                9:       ra = $urandom;
                default: begin
                    ra  = BASE + 32'h4;
                    rwe = 1'b0;
                end
            endcase
            rrst = $urandom_range(0, 499) == 0;
            cyc(rwe, ra, rd, rrst);
        end
        idle(5 * FRAME);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
